// File: rtl/mem_stream_pkg.sv
// Shared types and helpers for the memory stream reader.
package mem_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Skid FIFO depth: one slot per pipe stage plus the output head.
    function automatic int unsigned fifo_depth(input int unsigned read_latency);
        return read_latency + 32'd2;
    endfunction

    // Next word address, wrapping at the last word for any depth.
    function automatic int unsigned wrap_incr(input int unsigned addr, input int unsigned depth);
        return (addr == depth - 32'd1) ? 32'd0 : addr + 32'd1;
    endfunction

endpackage

// File: rtl/mem_rd_skid_fifo.sv
// Small shift-register FIFO whose head entry is a plain flop, so the stream
// outputs are driven straight from registers.
module mem_rd_skid_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             push_data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             head_o,
    output logic                         head_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             valid_q;
    logic             valid_d;

    // Pop shifts every entry toward the head; push lands just behind the
    // last occupied slot after any pop this cycle.
    always_comb begin
        data_d  = data_q;
        count_d = count_q;
        if (pop_i && (count_q != '0)) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                data_d[i] = data_q[i+1];
            end
            count_d = count_q - CW'(1);
        end
        if (push_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (count_d == CW'(i)) begin
                    data_d[i] = push_data_i;
                end
            end
            count_d = count_d + CW'(1);
        end
        valid_d = (count_d != '0);
    end

    // Storage, occupancy and head-valid registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
            count_q <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= data_d[i];
            end
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    assign head_o       = data_q[0];
    assign head_valid_o = valid_q;
    assign count_o      = count_q;

endmodule

// File: rtl/mem_stream_reader.sv
// Read-side engine for the simple dual-port buffer memory: walks a commanded
// address range on the read port and replays the words as an AXI4-Stream.
// Optional build macro MEM_STREAM_READER_PERF_EN adds the stall_cnt output.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned DATA_SIZE    = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(DEPTH)-1:0]     start_addr,
    input  logic [$clog2(DEPTH+1)-1:0]   length,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(DEPTH)-1:0]     addrb,
    input  logic [DATA_SIZE-1:0]         doutb,
    output logic [DATA_SIZE-1:0]         m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast
`ifdef MEM_STREAM_READER_PERF_EN
    ,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam int unsigned LW         = $clog2(DEPTH + 1);
    localparam int unsigned PW         = READ_LATENCY + 1;
    localparam int unsigned FIFO_DEPTH = fifo_depth(READ_LATENCY);
    localparam int unsigned FCW        = $clog2(FIFO_DEPTH + 1);

    state_e            state_q;
    logic [AW-1:0]     addr_q;
    logic [LW-1:0]     remaining_q;
    logic              busy_q;
    logic              done_q;
    logic [PW-1:0]     pipe_vld_q;
    logic [PW-1:0]     pipe_last_q;

    logic [LW-1:0]     len_sat_c;
    logic [AW-1:0]     next_addr_c;
    logic              pop_c;
    logic              start_acc_c;
    logic              credit_ok_c;
    logic              issue_c;
    logic              issue_last_c;
    int unsigned       inflight_c;

    logic [FCW-1:0]    fifo_count;
    logic [DATA_SIZE:0] fifo_head;
    logic              fifo_valid;

    // Issue decision: the start edge issues the first read itself; later reads
    // need a FIFO slot reserved for every word still travelling in the pipe.
    always_comb begin
        len_sat_c   = (32'(length) > DEPTH) ? LW'(DEPTH) : length;
        next_addr_c = AW'(wrap_incr(32'(addr_q), DEPTH));
        pop_c       = fifo_valid && m_axis_tready;
        start_acc_c = (state_q == IDLE) && start;
        inflight_c  = 32'd0;
        for (int i = 0; i < int'(PW); i++) begin
            inflight_c = inflight_c + 32'(pipe_vld_q[i]);
        end
        credit_ok_c  = (32'(fifo_count) + inflight_c) < (FIFO_DEPTH + 32'(pop_c));
        issue_c      = 1'b0;
        issue_last_c = 1'b0;
        if (start_acc_c) begin
            issue_c      = (len_sat_c != '0);
            issue_last_c = (len_sat_c == LW'(1));
        end else if (state_q == READ) begin
            issue_c      = (remaining_q != '0) && credit_ok_c;
            issue_last_c = (remaining_q == LW'(1));
        end
    end

    // Read-latency pipe: a word is captured from doutb as its bit leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            pipe_vld_q  <= {pipe_vld_q[PW-2:0], issue_c};
            pipe_last_q <= {pipe_last_q[PW-2:0], issue_last_c};
        end
    end

    // Transfer control FSM with registered busy/done/address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (issue_c) begin
                addr_q <= start_acc_c ? start_addr : next_addr_c;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len_sat_c == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            remaining_q <= len_sat_c - LW'(1);
                            busy_q      <= 1'b1;
                            state_q     <= READ;
                        end
                    end
                end
                READ: begin
                    if (issue_c) begin
                        remaining_q <= remaining_q - LW'(1);
                    end
                    if ((remaining_q == '0) || (issue_c && (remaining_q == LW'(1)))) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop_c && fifo_head[DATA_SIZE]) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    mem_rd_skid_fifo #(
        .WIDTH (DATA_SIZE + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (pipe_vld_q[PW-1]),
        .push_data_i  ({pipe_last_q[PW-1], doutb}),
        .pop_i        (pop_c),
        .head_o       (fifo_head),
        .head_valid_o (fifo_valid),
        .count_o      (fifo_count)
    );

`ifdef MEM_STREAM_READER_PERF_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of backpressured cycles for the current transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (start_acc_c) begin
            stall_cnt_q <= '0;
        end else if (busy_q && fifo_valid && !m_axis_tready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign busy          = busy_q;
    assign done          = done_q;
    assign addrb         = addr_q;
    assign m_axis_tdata  = fifo_head[DATA_SIZE-1:0];
    assign m_axis_tlast  = fifo_head[DATA_SIZE];
    assign m_axis_tvalid = fifo_valid;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a latency-1 memory model.
module tb_mem_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  start_addr;
    logic [3:0]  length;
    logic        busy;
    logic        done;
    logic [2:0]  addrb;
    logic [31:0] doutb;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
`ifdef MEM_STREAM_READER_PERF_EN
    logic [15:0] stall_cnt;
`endif

    logic [31:0] mem [8];
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          fill;
        logic [2:0]  a;
        logic [3:0]  l;
        logic [15:0] pat;
        bit          poke;
        int          beats;
        logic [31:0] last;
        int          stalls;
    } vec_t;

    vec_t vecs [8];

    always #5 clk = ~clk;

    always @(posedge clk) doutb <= mem[addrb];

    mem_stream_reader #(
        .DEPTH        (8),
        .DATA_SIZE    (32),
        .READ_LATENCY (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_addr    (start_addr),
        .length        (length),
        .busy          (busy),
        .done          (done),
        .addrb         (addrb),
        .doutb         (doutb),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast)
`ifdef MEM_STREAM_READER_PERF_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_mem(input int sel);
        for (int i = 0; i < 8; i++) begin
            mem[i] = (sel == 0) ? 32'(32'h11111111 * (i + 1)) : 32'(32'hFE + i);
        end
    endtask

    task automatic run_xfer(input vec_t v, input int id);
        int k, beats, first_v, hs_cyc;
        bit done_seen, stalled, rdy_bit;
        logic [31:0] held_d, last_d;
        logic        held_l;
        k = 0; beats = 0; first_v = -1; hs_cyc = 0;
        done_seen = 0; stalled = 0; held_d = '0; held_l = 1'b0; last_d = '0;
        fill_mem(v.fill);
        @(negedge clk);
        start = 1'b1; start_addr = v.a; length = v.l; tready = 1'b1;
        for (int cyc = 1; cyc <= 80 && !done_seen; cyc++) begin
            @(negedge clk);
            start = v.poke && (cyc == 2 || cyc == 5);
            if (start) begin
                start_addr = 3'd4;
                length     = 4'd1;
            end
            if (cyc == 1)
                chk($sformatf("v%0d busy_start", id), 64'(busy), 64'(v.beats != 0));
            if (v.pat == 16'hFFFF && cyc <= v.beats)
                chk($sformatf("v%0d addrb c%0d", id, cyc), 64'(addrb), 64'((int'(v.a) + cyc - 1) % 8));
            if (stalled)
                chk($sformatf("v%0d hold c%0d", id, cyc), {30'd0, tvalid, tlast, tdata}, {30'd0, 1'b1, held_l, held_d});
            if (done) begin
                done_seen = 1;
                chk($sformatf("v%0d done_time", id), 64'(cyc), 64'(hs_cyc + 1));
                chk($sformatf("v%0d busy_at_done", id), 64'(busy), 64'd0);
            end
            stalled = 0;
            if (tvalid) begin
                if (first_v < 0) first_v = cyc;
                rdy_bit = v.pat[k % 16];
                tready  = rdy_bit;
                k++;
                if (rdy_bit) begin
                    chk($sformatf("v%0d data b%0d", id, beats), 64'(tdata), 64'(mem[(int'(v.a) + beats) % 8]));
                    chk($sformatf("v%0d tlast b%0d", id, beats), 64'(tlast), 64'(beats == v.beats - 1));
                    if (tlast) begin
                        hs_cyc = cyc;
                        last_d = tdata;
                    end
                    beats++;
                end else begin
                    stalled = 1;
                    held_d  = tdata;
                    held_l  = tlast;
                end
            end else begin
                tready = 1'b1;
            end
        end
        start = 1'b0;
        chk($sformatf("v%0d done_seen", id), 64'(done_seen), 64'd1);
        chk($sformatf("v%0d beats", id), 64'(beats), 64'(v.beats));
        chk($sformatf("v%0d first_valid", id), 64'(first_v), 64'((v.beats > 0) ? 3 : -1));
        if (v.beats > 0)
            chk($sformatf("v%0d last_data", id), 64'(last_d), 64'(v.last));
        if (v.pat == 16'hFFFF && v.beats > 0)
            chk($sformatf("v%0d burst_span", id), 64'(hs_cyc - first_v + 1), 64'(v.beats));
        @(negedge clk);
        chk($sformatf("v%0d idle_after", id), {61'd0, done, tvalid, busy}, 64'd0);
`ifdef MEM_STREAM_READER_PERF_EN
        chk($sformatf("v%0d stall_cnt", id), 64'(stall_cnt), 64'(v.stalls));
`endif
        tready = 1'b1;
    endtask

    initial begin
        int beats;
        vec_t post;
        vecs[0] = '{0, 3'd0, 4'd2, 16'hFFFF, 1'b0, 2, 32'h22222222, 0};
        vecs[1] = '{1, 3'd0, 4'd8, 16'hFFFF, 1'b0, 8, 32'h00000105, 0};
        vecs[2] = '{1, 3'd0, 4'd8, 16'h9A69, 1'b0, 8, 32'h00000105, 8};
        vecs[3] = '{1, 3'd6, 4'd4, 16'hFFFF, 1'b0, 4, 32'h000000FF, 0};
        vecs[4] = '{1, 3'd3, 4'd9, 16'hFFFF, 1'b0, 8, 32'h00000100, 0};
        vecs[5] = '{1, 3'd5, 4'd0, 16'hFFFF, 1'b0, 0, 32'h00000000, 0};
        vecs[6] = '{1, 3'd7, 4'd1, 16'hFFFE, 1'b0, 1, 32'h00000105, 1};
        vecs[7] = '{1, 3'd0, 4'd8, 16'hFFFF, 1'b1, 8, 32'h00000105, 0};
        post    = '{1, 3'd2, 4'd1, 16'hFFFF, 1'b0, 1, 32'h00000100, 0};

        rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0; tready = 1'b1;
        fill_mem(1);
        repeat (2) @(negedge clk);
        chk("reset busy",   64'(busy),   64'd0);
        chk("reset done",   64'(done),   64'd0);
        chk("reset addrb",  64'(addrb),  64'd0);
        chk("reset tvalid", 64'(tvalid), 64'd0);
        chk("reset tlast",  64'(tlast),  64'd0);
        chk("reset tdata",  64'(tdata),  64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_xfer(vecs[i], i);
        end

        // Reset in the middle of an 8-word transfer.
        fill_mem(1);
        @(negedge clk);
        start = 1'b1; start_addr = 3'd0; length = 4'd8; tready = 1'b1;
        beats = 0;
        for (int cyc = 1; cyc <= 40 && beats < 3; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (tvalid && tready) beats++;
        end
        chk("mid beats_before_reset", 64'(beats), 64'd3);
        @(negedge clk);
        chk("mid tvalid_before_reset", 64'(tvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid async tvalid", 64'(tvalid), 64'd0);
        chk("mid async busy",   64'(busy),   64'd0);
        chk("mid async addrb",  64'(addrb),  64'd0);
        chk("mid async done",   64'(done),   64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            chk($sformatf("mid quiet c%0d", cyc), {62'd0, tvalid, busy}, 64'd0);
        end
        run_xfer(post, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
